// File: rtl/sp_mem_pkg.sv
// sp_mem_pkg: shared sizes, requester ids and response record for the data-memory arbiter
package sp_mem_pkg;
  localparam int DEPTH = 4096;
  localparam int DATA_W = 32;
  localparam int ADDR_W = $clog2(DEPTH);
  typedef enum logic {REQ_CORE = 1'b0, REQ_DBG = 1'b1} req_id_e;
  typedef struct packed {
    logic    valid;
    req_id_e owner;
    logic    is_read;
    logic    err;
  } rsp_t;
endpackage

// File: rtl/sp_dmem_arbiter_if.sv
// sp_dmem_arbiter_if: core, debug and memory-side signals of the data-memory arbiter
interface sp_dmem_arbiter_if;
  import sp_mem_pkg::*;
  logic              c_req, c_we, c_gnt, c_ack, c_err;
  logic [31:0]       c_addr;
  logic [DATA_W-1:0] c_wdata, c_rdata;
  logic              d_req, d_we, d_gnt, d_ack, d_err;
  logic [31:0]       d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_en, mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output c_gnt, c_ack, c_err, c_rdata, d_gnt, d_ack, d_err, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata
  );
  modport master (
    output c_req, c_we, c_addr, c_wdata, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  c_gnt, c_ack, c_err, c_rdata, d_gnt, d_ack, d_err, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/sp_rr_pick.sv
// sp_rr_pick: combinational 2-way round-robin picker, one-hot grant
module sp_rr_pick
  import sp_mem_pkg::*;
(
  input  logic [1:0] req,
  input  req_id_e    prio,
  output logic [1:0] gnt
);
  assign gnt[0] = req[0] && (!req[1] || prio == REQ_CORE);
  assign gnt[1] = req[1] && (!req[0] || prio == REQ_DBG);
endmodule

// File: rtl/sp_dmem_arbiter.sv
// sp_dmem_arbiter: round-robin share of the single-port data memory between core and debug
module sp_dmem_arbiter
  import sp_mem_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  sp_dmem_arbiter_if.slave bus
);
  logic [1:0]        req, gnt;
  req_id_e           prio;
  rsp_t              rsp, rsp_nxt;
  logic              xfer, sel, we, oor, c_hit, d_hit;
  logic [31:0]       addr;
  logic [DATA_W-1:0] wdata, rd;
  assign req = {bus.d_req, bus.c_req} & {2{rst_n}};
  sp_rr_pick u_pick (.req(req), .prio(prio), .gnt(gnt));
  always_comb begin
    xfer    = |gnt;
    sel     = gnt[1];
    addr    = sel ? bus.d_addr : bus.c_addr;
    we      = sel ? bus.d_we : bus.c_we;
    wdata   = sel ? bus.d_wdata : bus.c_wdata;
    oor     = |addr[31:ADDR_W];
    rsp_nxt = '{valid: xfer, owner: sel ? REQ_DBG : REQ_CORE, is_read: !we, err: oor};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) prio <= REQ_CORE;
    else if (xfer) prio <= gnt[0] ? REQ_DBG : REQ_CORE;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rsp <= '0;
    else rsp <= rsp_nxt;
  // out-of-range transfers are still granted but never reach the memory
  always_comb begin
    bus.c_gnt     = gnt[0];
    bus.d_gnt     = gnt[1];
    bus.mem_en    = xfer && !oor;
    bus.mem_we    = xfer && !oor && we;
    bus.mem_addr  = xfer ? addr[ADDR_W-1:0] : '0;
    bus.mem_wdata = xfer ? wdata : '0;
    c_hit         = rsp.valid && rsp.owner == REQ_CORE;
    d_hit         = rsp.valid && rsp.owner == REQ_DBG;
    rd            = (rsp.is_read && !rsp.err) ? bus.mem_rdata : '0;
    bus.c_ack     = c_hit;
    bus.c_err     = c_hit && rsp.err;
    bus.c_rdata   = c_hit ? rd : '0;
    bus.d_ack     = d_hit;
    bus.d_err     = d_hit && rsp.err;
    bus.d_rdata   = d_hit ? rd : '0;
  end
endmodule

// File: tb/tb_sp_dmem_arbiter.sv
// tb_sp_dmem_arbiter: directed plus random stimulus against a transaction-level reference model
module tb_sp_dmem_arbiter;
  typedef struct {
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
  } rq_t;
  logic clk = 1'b0, rst_n = 1'b0, load = 1'b1;
  logic [31:0] mem [4096];
  logic [31:0] ref_mem [4096];
  rq_t cp, dp;
  int n_chk = 0, n_err = 0;
  int prio_m = 0, exp_owner = 0;
  logic exp_valid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;
  sp_dmem_arbiter_if bus ();
  sp_dmem_arbiter dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk)
    if (load) begin
      for (int i = 0; i < 4096; i++) mem[i] <= (i == 10) ? 32'd1 : 32'(i + 100);
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
      else bus.mem_rdata <= mem[bus.mem_addr];
    end
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic drive();
    bus.c_req = cp.req; bus.c_we = cp.we; bus.c_addr = cp.addr; bus.c_wdata = cp.wdata;
    bus.d_req = dp.req; bus.d_we = dp.we; bus.d_addr = dp.addr; bus.d_wdata = dp.wdata;
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {bus.c_gnt, bus.d_gnt, bus.mem_en, bus.mem_we,
                        bus.c_ack, bus.d_ack, bus.c_err, bus.d_err}, 0);
    chk({tag, "_mem"}, {bus.mem_addr, bus.mem_wdata}, 0);
    chk({tag, "_rdata"}, {bus.c_rdata, bus.d_rdata}, 0);
  endtask
  function automatic rq_t rnd();
    rq_t r;
    int k = $urandom_range(0, 19);
    r.req = 1'b1;
    r.we = 1'($urandom_range(0, 1));
    r.addr = (k == 0) ? $urandom : (k == 1) ? 32'd4096 : (k == 2) ? 32'd4095 : $urandom_range(0, 15);
    r.wdata = $urandom;
    return r;
  endfunction
  // one clock: check grant/memory strobes and the previous response, then advance the model
  task automatic cycle();
    int w;
    rq_t r;
    logic in_r;
    logic [31:0] exp_c, exp_d;
    drive();
    #2;
    w = (cp.req && dp.req) ? prio_m : cp.req ? 0 : dp.req ? 1 : -1;
    chk("c_gnt", bus.c_gnt, w == 0);
    chk("d_gnt", bus.d_gnt, w == 1);
    exp_c = (exp_valid && exp_owner == 0) ? exp_rdata : 0;
    exp_d = (exp_valid && exp_owner == 1) ? exp_rdata : 0;
    chk("c_ack", {bus.c_ack, bus.c_err}, {exp_valid && exp_owner == 0, exp_valid && exp_owner == 0 && exp_err});
    chk("d_ack", {bus.d_ack, bus.d_err}, {exp_valid && exp_owner == 1, exp_valid && exp_owner == 1 && exp_err});
    chk("c_rdata", bus.c_rdata, exp_c);
    chk("d_rdata", bus.d_rdata, exp_d);
    r = (w == 1) ? dp : cp;
    in_r = (w >= 0) && r.addr < 32'd4096;
    chk("mem_en", bus.mem_en, in_r);
    if (in_r) begin
      chk("mem_we", bus.mem_we, r.we);
      chk("mem_addr", bus.mem_addr, r.addr);
      if (r.we) chk("mem_wdata", bus.mem_wdata, r.wdata);
    end
    exp_valid = w >= 0;
    exp_owner = w;
    exp_err = (w >= 0) && !in_r;
    exp_rdata = (in_r && !r.we) ? ref_mem[r.addr[11:0]] : 0;
    if (in_r && r.we) ref_mem[r.addr[11:0]] = r.wdata;
    if (w == 0) begin prio_m = 1; cp.req = 1'b0; end
    if (w == 1) begin prio_m = 0; dp.req = 1'b0; end
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic do_reset();
    cp = '{1'b1, 1'b0, 32'd1, 32'd0};
    dp = '{1'b1, 1'b1, 32'd2, 32'd9};
    drive();
    rst_n = 1'b0;
    #2;
    chk_zero("rst");
    exp_valid = 1'b0;
    prio_m = 0;
    cp.req = 1'b0;
    dp.req = 1'b0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  initial begin
    for (int i = 0; i < 4096; i++) ref_mem[i] = (i == 10) ? 32'd1 : 32'(i + 100);
    do_reset();
    load = 1'b0;
    // reset arriving while a core read is in flight
    cp = '{1'b1, 1'b0, 32'd3, 32'd0};
    drive();
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 chk_zero("midrst");
    cp.req = 1'b0;
    exp_valid = 1'b0;
    prio_m = 0;
    drive();
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    cp = '{1'b1, 1'b0, 32'd20, 32'd0};
    dp = '{1'b1, 1'b0, 32'd21, 32'd0};
    cycle();
    cycle();
    cycle();
    // core write then read of address 5
    cp = '{1'b1, 1'b1, 32'd5, 32'hDEADBEEF};
    cycle();
    cp = '{1'b1, 1'b0, 32'd5, 32'd0};
    cycle();
    cycle();
    // both requesters hold reads for four cycles from reset
    do_reset();
    for (int i = 0; i < 4; i++) begin
      if (!cp.req) cp = '{1'b1, 1'b0, 32'(30 + i), 32'd0};
      if (!dp.req) dp = '{1'b1, 1'b0, 32'(40 + i), 32'd0};
      cycle();
    end
    cp.req = 1'b0;
    dp.req = 1'b0;
    cycle();
    // out-of-range on both ports
    cp = '{1'b1, 1'b0, 32'd4096, 32'd0};
    dp = '{1'b1, 1'b1, 32'hFFFFFFFF, 32'h12345678};
    cycle();
    cycle();
    cycle();
    // streamed reads 0..7
    for (int i = 0; i < 8; i++) begin
      cp = '{1'b1, 1'b0, 32'(i), 32'd0};
      cycle();
    end
    cycle();
    // same-address collision with prio on core
    do_reset();
    cp = '{1'b1, 1'b0, 32'd10, 32'd0};
    dp = '{1'b1, 1'b1, 32'd10, 32'd7};
    cycle();
    cycle();
    cp = '{1'b1, 1'b0, 32'd10, 32'd0};
    cycle();
    cycle();
    for (int i = 0; i < 400; i++) begin
      if (!cp.req && $urandom_range(0, 2) != 0) cp = rnd();
      if (!dp.req && $urandom_range(0, 2) != 0) dp = rnd();
      cycle();
    end
    cp.req = 1'b0;
    dp.req = 1'b0;
    cycle();
    cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
